// File: rtl/ldr_mem_sink_if.sv
// Loader handshake and SDRAM client write port bundled for ldr_mem_sink.
// The slave view belongs to the sink; the master view drives the loader and models the memory.
interface ldr_mem_sink_if #(
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned MEM_AW = 24
);
    localparam int unsigned CNT_W = 20;

    logic              ldr_oe;
    logic [ADDR_W-1:0] ldr_addr;
    logic [7:0]        ldr_wdat;
    logic              ldr_wr;
    logic              ldr_ack;
    logic              ldr_done;
    logic              mem_req;
    logic [MEM_AW-1:0] mem_addr;
    logic [15:0]       mem_wdat;
    logic [1:0]        mem_be;
    logic              mem_ack;
    logic              cpu_hold;
    logic [CNT_W-1:0]  wr_count;

    modport slave (
        input  ldr_oe, ldr_addr, ldr_wdat, ldr_wr, ldr_done, mem_ack,
        output ldr_ack, mem_req, mem_addr, mem_wdat, mem_be, cpu_hold, wr_count
    );

    modport master (
        output ldr_oe, ldr_addr, ldr_wdat, ldr_wr, ldr_done, mem_ack,
        input  ldr_ack, mem_req, mem_addr, mem_wdat, mem_be, cpu_hold, wr_count
    );
endinterface

// File: rtl/ldr_mem_sink.sv
// Loader-handshake responder: packs ioctl bytes into 16-bit words, writes them to an
// SDRAM client port with byte enables, and holds the CPU until the last word lands.
module ldr_mem_sink #(
    parameter int unsigned ADDR_W   = 20,
    parameter int unsigned MEM_AW   = 24,
    parameter int unsigned MEM_BASE = 0
) (
    input  logic          clk_sys,
    input  logic          reset,
    ldr_mem_sink_if.slave bus
);
    localparam int unsigned       CNT_W   = 20;
    localparam logic [MEM_AW-1:0] BASE    = MEM_AW'(MEM_BASE);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCEPT = 3'd1,
        S_FLUSH  = 3'd2,
        S_ACKH   = 3'd3,
        S_FINAL  = 3'd4,
        S_DONE   = 3'd5
    } state_e;

    typedef struct packed {
        logic [MEM_AW-1:0] addr;
        logic [15:0]       data;
        logic [1:0]        vld;
        logic              pend;
    } pack_t;

    state_e            state_q, state_d;
    pack_t             pk_q, pk_d;
    logic              brk_q, brk_d;
    logic [MEM_AW-1:0] nb_addr_q, nb_addr_d;
    logic              nb_lane_q, nb_lane_d;
    logic [7:0]        nb_data_q, nb_data_d;

    logic              ldr_ack_q, ldr_ack_d;
    logic              mem_req_q, mem_req_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic [15:0]       mem_wdat_q, mem_wdat_d;
    logic [1:0]        mem_be_q, mem_be_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic [CNT_W-1:0]  wr_count_q, wr_count_d;

    logic              take_byte;
    logic              same_word;
    logic [MEM_AW-1:0] in_waddr;
    pack_t             merged;
    pack_t             loaded;

    assign take_byte = bus.ldr_wr && bus.ldr_oe && !ldr_ack_q;
    assign in_waddr  = MEM_AW'(bus.ldr_addr[ADDR_W-1:1]) + BASE;

    // Latched byte viewed two ways: merged into the open word, or as a fresh word.
    always_comb begin : byte_eval
        same_word = pk_q.pend && (pk_q.addr == nb_addr_q) && !pk_q.vld[nb_lane_q];

        merged                 = pk_q;
        merged.vld[nb_lane_q]  = 1'b1;
        if (nb_lane_q) merged.data[15:8] = nb_data_q;
        else           merged.data[7:0]  = nb_data_q;

        loaded                 = '0;
        loaded.addr            = nb_addr_q;
        loaded.pend            = 1'b1;
        loaded.vld[nb_lane_q]  = 1'b1;
        if (nb_lane_q) loaded.data[15:8] = nb_data_q;
        else           loaded.data[7:0]  = nb_data_q;
    end

    always_ff @(posedge clk_sys or posedge reset) begin : state_reg
        if (reset) begin
            state_q    <= S_IDLE;
            pk_q       <= '0;
            brk_q      <= 1'b0;
            nb_addr_q  <= '0;
            nb_lane_q  <= 1'b0;
            nb_data_q  <= '0;
            ldr_ack_q  <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            mem_wdat_q <= '0;
            mem_be_q   <= '0;
            cpu_hold_q <= 1'b1;
            wr_count_q <= '0;
        end else begin
            state_q    <= state_d;
            pk_q       <= pk_d;
            brk_q      <= brk_d;
            nb_addr_q  <= nb_addr_d;
            nb_lane_q  <= nb_lane_d;
            nb_data_q  <= nb_data_d;
            ldr_ack_q  <= ldr_ack_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            mem_wdat_q <= mem_wdat_d;
            mem_be_q   <= mem_be_d;
            cpu_hold_q <= cpu_hold_d;
            wr_count_q <= wr_count_d;
        end
    end

    // A request always wins over ldr_done in IDLE, so a byte racing the done flag still lands.
    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (take_byte)         state_d = S_ACCEPT;
                else if (bus.ldr_done) state_d = pk_q.pend ? S_FINAL : S_DONE;
            end
            S_ACCEPT: begin
                if (same_word)      state_d = (merged.vld == 2'b11) ? S_FLUSH : S_ACKH;
                else if (pk_q.pend) state_d = S_FLUSH;
                else                state_d = S_ACKH;
            end
            S_FLUSH: if (bus.mem_ack)  state_d = S_ACKH;
            S_ACKH:  if (!bus.ldr_wr)  state_d = S_IDLE;
            S_FINAL: if (bus.mem_ack)  state_d = S_DONE;
            S_DONE:                    state_d = S_DONE;
            default:                   state_d = S_IDLE;
        endcase
    end

    // Memory outputs are loaded once on flush entry and left untouched until mem_ack.
    always_comb begin : outputs
        pk_d       = pk_q;
        brk_d      = brk_q;
        nb_addr_d  = nb_addr_q;
        nb_lane_d  = nb_lane_q;
        nb_data_d  = nb_data_q;
        ldr_ack_d  = ldr_ack_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        mem_wdat_d = mem_wdat_q;
        mem_be_d   = mem_be_q;
        cpu_hold_d = 1'b1;
        wr_count_d = wr_count_q;

        case (state_q)
            S_IDLE: begin
                ldr_ack_d = 1'b0;
                if (take_byte) begin
                    nb_addr_d = in_waddr;
                    nb_lane_d = bus.ldr_addr[0];
                    nb_data_d = bus.ldr_wdat;
                end else if (bus.ldr_done) begin
                    if (pk_q.pend) begin
                        mem_req_d  = 1'b1;
                        mem_addr_d = pk_q.addr;
                        mem_wdat_d = pk_q.data;
                        mem_be_d   = pk_q.vld;
                    end else begin
                        cpu_hold_d = 1'b0;
                    end
                end
            end
            S_ACCEPT: begin
                if (same_word) begin
                    pk_d = merged;
                    if (merged.vld == 2'b11) begin
                        brk_d      = 1'b0;
                        mem_req_d  = 1'b1;
                        mem_addr_d = merged.addr;
                        mem_wdat_d = merged.data;
                        mem_be_d   = merged.vld;
                    end
                end else if (pk_q.pend) begin
                    brk_d      = 1'b1;
                    mem_req_d  = 1'b1;
                    mem_addr_d = pk_q.addr;
                    mem_wdat_d = pk_q.data;
                    mem_be_d   = pk_q.vld;
                end else begin
                    pk_d = loaded;
                end
            end
            S_FLUSH: begin
                if (bus.mem_ack) begin
                    mem_req_d  = 1'b0;
                    ldr_ack_d  = 1'b1;
                    brk_d      = 1'b0;
                    pk_d       = brk_q ? loaded : pack_t'('0);
                    wr_count_d = (wr_count_q == CNT_MAX) ? wr_count_q : wr_count_q + CNT_W'(1);
                end
            end
            S_ACKH: begin
                ldr_ack_d = bus.ldr_wr;
            end
            S_FINAL: begin
                if (bus.mem_ack) begin
                    mem_req_d  = 1'b0;
                    pk_d       = '0;
                    cpu_hold_d = 1'b0;
                    wr_count_d = (wr_count_q == CNT_MAX) ? wr_count_q : wr_count_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                ldr_ack_d  = 1'b0;
                cpu_hold_d = 1'b0;
            end
            default: begin
                ldr_ack_d = 1'b0;
                mem_req_d = 1'b0;
            end
        endcase
    end

    assign bus.ldr_ack  = ldr_ack_q;
    assign bus.mem_req  = mem_req_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_wdat = mem_wdat_q;
    assign bus.mem_be   = mem_be_q;
    assign bus.cpu_hold = cpu_hold_q;
    assign bus.wr_count = wr_count_q;
endmodule

// File: tb/tb_ldr_mem_sink.sv
// Bench for ldr_mem_sink: loader driver plus byte-pair reference model feeding a write
// scoreboard that a randomly stalling SDRAM responder drains.
module tb_ldr_mem_sink;
    localparam int unsigned ADDR_W = 20;
    localparam int unsigned MEM_AW = 24;
    localparam int unsigned BASE   = 32'h080000;
    localparam int unsigned HALF   = 5;

    typedef struct packed {
        logic [MEM_AW-1:0] addr;
        logic [15:0]       wdat;
        logic [1:0]        be;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #HALF clk = ~clk;

    ldr_mem_sink_if #(.ADDR_W(ADDR_W), .MEM_AW(MEM_AW)) bus ();

    ldr_mem_sink #(.ADDR_W(ADDR_W), .MEM_AW(MEM_AW), .MEM_BASE(BASE)) dut (
        .clk_sys (clk),
        .reset   (rst),
        .bus     (bus)
    );

    int  n_checks = 0;
    int  n_pass   = 0;
    wr_t exp_q[$];
    int  exp_writes = 0;

    // Reference: the one word still being assembled from loader bytes.
    logic              m_pend = 1'b0;
    logic [MEM_AW-1:0] m_addr = '0;
    logic [15:0]       m_data = '0;
    logic [1:0]        m_vld  = '0;

    int  force_delay = -1;
    bit  hold_ack    = 1'b0;
    int  last_req_cycles = 0;
    time ack_edge_t  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [MEM_AW-1:0] word_of(input logic [ADDR_W-1:0] a);
        return MEM_AW'(a >> 1) + MEM_AW'(BASE);
    endfunction

    task automatic model_push();
        wr_t w;
        w.addr = m_addr;
        w.wdat = m_data;
        w.be   = m_vld;
        exp_q.push_back(w);
        exp_writes++;
        m_pend = 1'b0;
        m_vld  = '0;
        m_data = '0;
    endtask

    task automatic model_byte(input logic [ADDR_W-1:0] a, input logic [7:0] d, output bit flushes);
        logic [MEM_AW-1:0] w;
        int lane;
        w = word_of(a);
        lane = a[0] ? 1 : 0;
        flushes = 1'b0;
        if (m_pend && m_addr == w && !m_vld[lane]) begin
            m_data[lane*8 +: 8] = d;
            m_vld[lane] = 1'b1;
            if (m_vld == 2'b11) begin
                model_push();
                flushes = 1'b1;
            end
        end else begin
            if (m_pend) begin
                model_push();
                flushes = 1'b1;
            end
            m_pend = 1'b1;
            m_addr = w;
            m_data = '0;
            m_vld  = '0;
            m_data[lane*8 +: 8] = d;
            m_vld[lane] = 1'b1;
        end
    endtask

    task automatic send_byte(input logic [ADDR_W-1:0] a, input logic [7:0] d, input bit with_done);
        bit fl;
        bit got;
        int cnt;
        model_byte(a, d, fl);
        @(negedge clk);
        bus.ldr_addr = a;
        bus.ldr_wdat = d;
        bus.ldr_wr   = 1'b1;
        if (with_done) bus.ldr_done = 1'b1;
        cnt = 0;
        got = 1'b0;
        while (!got && cnt < 400) begin
            @(negedge clk);
            cnt++;
            if (bus.ldr_ack) got = 1'b1;
        end
        chk("ack_seen", 64'(got), 64'd1);
        if (got && fl)  chk("flush_ack_lat", 64'($time - ack_edge_t), 64'(HALF));
        if (got && !fl) chk("ack_lat", 64'(cnt), 64'd3);
        bus.ldr_wr = 1'b0;
        @(negedge clk);
        chk("ack_fall", 64'(bus.ldr_ack), 64'd0);
    endtask

    task automatic finish_session();
        int cnt;
        if (m_pend) model_push();
        @(negedge clk);
        bus.ldr_done = 1'b1;
        cnt = 0;
        while (bus.cpu_hold && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
        chk("cpu_hold_release", 64'(bus.cpu_hold), 64'd0);
        chk("wr_count", 64'(bus.wr_count), 64'(exp_writes));
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.ldr_wr   = 1'b0;
        bus.ldr_done = 1'b0;
        bus.ldr_oe   = 1'b1;
        bus.ldr_addr = '0;
        bus.ldr_wdat = '0;
        exp_q.delete();
        m_pend = 1'b0;
        m_vld  = '0;
        m_data = '0;
        m_addr = '0;
        exp_writes = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    always @(posedge clk) if (bus.mem_ack) ack_edge_t <= $time;

    // SDRAM client: random accept delay, checks the request holds steady, scores each write.
    initial begin : sdram
        bit  busy;
        int  wait_n;
        int  req_cycles;
        wr_t cap;
        wr_t cur;
        wr_t e;
        busy = 1'b0;
        wait_n = 0;
        req_cycles = 0;
        cap = '0;
        bus.mem_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy = 1'b0;
                bus.mem_ack = 1'b0;
            end else if (bus.mem_ack) begin
                bus.mem_ack = 1'b0;
                busy = 1'b0;
                chk("req_drop", 64'(bus.mem_req), 64'd0);
            end else if (bus.mem_req) begin
                cur.addr = bus.mem_addr;
                cur.wdat = bus.mem_wdat;
                cur.be   = bus.mem_be;
                if (!busy) begin
                    busy = 1'b1;
                    cap = cur;
                    req_cycles = 0;
                    wait_n = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 3));
                    force_delay = -1;
                end else begin
                    chk("req_stable", 64'(cur), 64'(cap));
                end
                req_cycles++;
                if (!hold_ack) begin
                    if (wait_n == 0) begin
                        bus.mem_ack = 1'b1;
                        last_req_cycles = req_cycles;
                        chk("write_queued", 64'(exp_q.size() != 0), 64'd1);
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            chk("write", 64'(cap), 64'(e));
                        end
                    end else begin
                        wait_n--;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit fl;
        int cnt;
        logic [ADDR_W-1:0] a;
        bus.ldr_oe   = 1'b1;
        bus.ldr_wr   = 1'b0;
        bus.ldr_done = 1'b0;
        bus.ldr_addr = '0;
        bus.ldr_wdat = '0;
        repeat (2) @(negedge clk);
        chk("rst_ldr_ack",  64'(bus.ldr_ack),  64'd0);
        chk("rst_mem_req",  64'(bus.mem_req),  64'd0);
        chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        chk("rst_mem_wdat", 64'(bus.mem_wdat), 64'd0);
        chk("rst_mem_be",   64'(bus.mem_be),   64'd0);
        chk("rst_cpu_hold", 64'(bus.cpu_hold), 64'd1);
        chk("rst_wr_count", 64'(bus.wr_count), 64'd0);

        // Pair, address break, then final partial word; DONE must ignore requests.
        do_reset();
        send_byte(20'h00000, 8'h11, 1'b0);
        send_byte(20'h00001, 8'h22, 1'b0);
        chk("pair_wr_count", 64'(bus.wr_count), 64'd1);
        send_byte(20'h00010, 8'h33, 1'b0);
        send_byte(20'h00020, 8'h44, 1'b0);
        finish_session();
        @(negedge clk);
        bus.ldr_addr = 20'h00002;
        bus.ldr_wr   = 1'b1;
        repeat (6) @(negedge clk);
        chk("done_ignores_wr_ack", 64'(bus.ldr_ack), 64'd0);
        chk("done_ignores_wr_req", 64'(bus.mem_req), 64'd0);
        bus.ldr_wr = 1'b0;

        // Odd lone byte arriving together with ldr_done; inactive session ignored.
        do_reset();
        bus.ldr_oe   = 1'b0;
        bus.ldr_addr = 20'h00005;
        bus.ldr_wr   = 1'b1;
        repeat (6) @(negedge clk);
        chk("oe_low_no_ack", 64'(bus.ldr_ack), 64'd0);
        bus.ldr_wr = 1'b0;
        bus.ldr_oe = 1'b1;
        send_byte(20'h00003, 8'hAA, 1'b1);
        finish_session();

        // Long stall during a pair flush.
        do_reset();
        send_byte(20'h00040, 8'h5A, 1'b0);
        force_delay = 15;
        send_byte(20'h00041, 8'hA5, 1'b0);
        chk("stall_req_cycles", 64'(last_req_cycles), 64'd16);

        // Reset in the middle of a held flush.
        do_reset();
        send_byte(20'h00000, 8'h55, 1'b0);
        hold_ack = 1'b1;
        model_byte(20'h00004, 8'h66, fl);
        @(negedge clk);
        bus.ldr_addr = 20'h00004;
        bus.ldr_wdat = 8'h66;
        bus.ldr_wr   = 1'b1;
        cnt = 0;
        while (!bus.mem_req && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("req_before_rst", 64'(bus.mem_req), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_req",  64'(bus.mem_req),  64'd0);
        chk("rst_async_hold", 64'(bus.cpu_hold), 64'd1);
        bus.ldr_wr = 1'b0;
        hold_ack = 1'b0;
        do_reset();
        send_byte(20'h00000, 8'h01, 1'b0);
        send_byte(20'h00001, 8'h02, 1'b0);
        chk("post_rst_wr_count", 64'(bus.wr_count), 64'd1);

        // Sequential stream, then random scatter, then close the session.
        do_reset();
        for (int i = 0; i < 256; i++) send_byte(ADDR_W'(i), 8'($urandom), 1'b0);
        chk("stream_wr_count", 64'(bus.wr_count), 64'd128);
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 7) == 0) a = ADDR_W'($urandom);
            else                            a = ADDR_W'(32'h100 + $urandom_range(0, 15));
            send_byte(a, 8'($urandom), 1'b0);
        end
        finish_session();

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ldr_mem_sink.md
Name: ldr_mem_sink

Overview:
- Core-side responder for the ROM/BIOS loader handshake (LDR_WR/LDR_ACK/LDR_DONE) driven by the MiSTer top level from ioctl.
- Accepts one byte per request and packs even/odd byte pairs into 16-bit words.
- Issues word writes with byte enables to an SDRAM controller client port.
- Holds the CPU off until the final partial word is flushed.

Parameters:
- ADDR_W, 20, width of loader byte address.
- MEM_AW, 24, width of memory word address.
- MEM_BASE, 0, word offset added to every loader word address (must fit MEM_AW).

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ldr_oe  in  1  loader session active (ioctl_download & ~done).
- ldr_addr  in  ADDR_W  byte address; valid while ldr_wr=1.
- ldr_wdat  in  8  byte data; valid while ldr_wr=1.
- ldr_wr  in  1  request level; held high until the rising edge of ldr_ack.
- ldr_ack  out  1  acknowledge level (4-phase).
- ldr_done  in  1  level; download finished; sticky from the source.
- mem_req  out  1  write request level.
- mem_addr  out  MEM_AW  word address = MEM_BASE + ldr_addr[ADDR_W-1:1].
- mem_wdat  out  16  [7:0]=even byte, [15:8]=odd byte.
- mem_be  out  2  byte enables; bit0=low, bit1=high.
- mem_ack  in  1  one-cycle pulse; write accepted.
- cpu_hold  out  1  hold CPU in reset.
- wr_count  out  20  number of memory word writes completed (saturates at all-ones).

Behaviour:
- Reset values: ldr_ack=0, mem_req=0, mem_addr=0, mem_wdat=0, mem_be=0, cpu_hold=1, wr_count=0. Pack register is empty.
- Pack register contents: a word address, a 16-bit data word, 2 valid bits, and a pending flag.
- States:
  - IDLE: waits for ldr_wr=1 with ldr_ack=0.
  - ACCEPT: takes a byte.
  - FLUSH: mem_req held.
  - ACKH: ldr_ack=1.
  - FINAL: flushes the last word.
  - DONE: terminal state.
- IDLE→ACCEPT on ldr_wr=1 with ldr_ack=0. ACCEPT evaluates the byte:
  - Pending and same word address, byte lane not yet valid: merge, set the lane valid bit. If both lanes are now valid → FLUSH, otherwise → ACKH.
  - Pending and different word address, or lane already valid: FLUSH the old word first. On mem_ack, load the new byte into the now-empty pack register (no further flush unless the pair completes), then → ACKH.
  - Not pending: load the byte and set the lane valid → ACKH.
- FLUSH: mem_req=1; mem_addr/mem_wdat/mem_be stable from the first cycle until and including the mem_ack cycle. On mem_ack: mem_req=0 in the next cycle, wr_count+1, pending cleared.
  - If the flush was caused by pair completion → ACKH.
  - If it was caused by an address break → load the new byte, then → ACKH.
- ACKH: ldr_ack=1 until ldr_wr is sampled 0. ldr_ack falls in the cycle after ldr_wr is sampled low (max 1 cycle). ACKH→IDLE.
  - Required because the source edge-detects ack; ack must be low before the next request or the handshake deadlocks.
- Latency:
  - Non-flushing byte: ldr_ack rises 2 cycles after ldr_wr is sampled high.
  - Flushing byte: ldr_ack rises 1 cycle after the mem_ack cycle.
- ldr_done=1 seen in IDLE: if pending → FINAL (flush as FLUSH; mem_be = valid bits), else → DONE. ldr_done is ignored mid-transaction; it is acted on only at the return to IDLE.
- DONE: cpu_hold=0; the block ignores ldr_wr. Leaving DONE requires reset.
- cpu_hold = 1 in every state except DONE, regardless of ldr_oe. ldr_oe=0 with ldr_wr=1 is ignored (no ack).
- mem_be for a lone byte: 01 (even) or 10 (odd). mem_wdat unused lane is 0.
- Address arithmetic: word address is the upper ADDR_W-1 bits of ldr_addr, zero-extended to MEM_AW, plus MEM_BASE modulo 2^MEM_AW. Wrap at the top is silent.
- mem_ack outside FLUSH/FINAL is ignored.
- Reset mid-operation: mem_req drops immediately (async). The pending byte is lost; cpu_hold=1.
- Simultaneous ldr_done and ldr_wr in IDLE: the byte is processed first.

Test Plan:
- Bytes 0x11@0x00000, 0x22@0x00001 → one write: mem_addr=0, mem_wdat=0x2211, mem_be=11, wr_count=1. Two acks, each dropping ≤1 cycle after ldr_wr falls.
- Bytes @0x00010, then @0x00020 (address break) → first write mem_addr=8, be=01. Second byte is acked only after that mem_ack. ldr_done → FINAL write mem_addr=0x10, be=01. cpu_hold falls after the final mem_ack.
- MEM_BASE=0x080000, byte 0xAA@0x00003 then ldr_done → mem_addr=0x080001, wdat=0xAA00, be=10.
- mem_ack delayed 15 cycles during flush → mem_req/mem_addr/mem_wdat stable for all 16 cycles; ldr_ack stays 0 until the cycle after mem_ack.
- Reset asserted while mem_req=1 → mem_req=0 and cpu_hold=1 asynchronously. After release, bytes 0x01/0x02@0/1 produce wdat=0x0201 with no stale data.
- Stream 256 sequential bytes at source-max rate → 128 writes, wr_count=128, no deadlock, ldr_ack never high while in IDLE.
